// File: rtl/zero_run_serializer.sv
// zero_run_serializer
//
// Takes a trailing-zero count N and does two things with it:
//   - registers the parallel word 1 << N (or all zeros when N equals DATA_WIDTH)
//   - streams the same word LSB-first as N zero bits followed by a single
//     terminating one bit (no terminator when N equals DATA_WIDTH)
// Counts larger than DATA_WIDTH are clamped to DATA_WIDTH.
//
// Ports
//   clk        : single clock, rising edge
//   resetn     : synchronous active-low reset
//   din        : trailing-zero count, $clog2(DATA_WIDTH)+1 bits
//   din_valid  : din holds a count
//   din_ready  : block is idle and will take a count
//   dout       : current serial bit, LSB-first
//   dout_valid : dout holds a bit
//   dout_ready : consumer takes dout this cycle
//   dout_last  : dout is the final bit of the run
//   word       : parallel word for the last accepted count
//
// Every output comes straight from a flop. The next-state logic computes the
// next state, and the output decode works on that next state, so nothing
// combinational sits between an input pin and an output pin.

module zero_run_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [$clog2(DATA_WIDTH):0]   din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic [DATA_WIDTH-1:0]         word
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] MAX_N = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    TERM  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  no_term_q, no_term_d;
  logic [CW-1:0]         nc;
  logic [DATA_WIDTH-1:0] word_d;
  logic                  accept;
  logic                  out_hs;
  logic                  dout_d, dout_valid_d, dout_last_d, din_ready_d;

  // Clamp oversized counts, and name the two handshakes.
  assign nc     = (din > MAX_N) ? MAX_N : din;
  assign accept = din_valid & din_ready;
  assign out_hs = dout_valid & dout_ready;

  // State register: holds the FSM state, the remaining zero count, whether
  // this run has a terminator, the parallel word and the registered outputs.
  // Reset drops any run in progress and leaves the block idle and ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      no_term_q  <= 1'b0;
      word       <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      din_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      no_term_q  <= no_term_d;
      word       <= word_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      dout_last  <= dout_last_d;
      din_ready  <= din_ready_d;
    end
  end

  // Next-state logic. In IDLE a count is latched along with its word. A count
  // of zero goes straight to the terminator. Otherwise ZEROS counts down one
  // bit per output handshake. When the last zero is taken, we go to TERM, or
  // straight back to IDLE for a full-width count that has no terminator.
  // With no handshake, nothing changes, which is what holds the stream steady
  // during a stall.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    no_term_d = no_term_q;
    word_d    = word;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d    = (nc == MAX_N) ? '0 : (DATA_WIDTH'(1) << nc);
          no_term_d = (nc == MAX_N);
          count_d   = nc;
          state_d   = (nc == '0) ? TERM : ZEROS;
        end
      end
      ZEROS: begin
        if (out_hs) begin
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = no_term_q ? IDLE : TERM;
          end
        end
      end
      TERM: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode of the next state. It feeds the output flops, so the
  // outputs track the state one-for-one.
  // dout_last marks the terminator. For a run with no terminator, it marks
  // the final zero instead, which is the ZEROS cycle with one zero remaining.
  always_comb begin
    dout_d       = (state_d == TERM);
    dout_valid_d = (state_d != IDLE);
    din_ready_d  = (state_d == IDLE);
    dout_last_d  = (state_d == TERM) ||
                   ((state_d == ZEROS) && no_term_d && (count_d == CW'(1)));
  end

endmodule

// File: tb/tb_zero_run_serializer.sv
// tb_zero_run_serializer
//
// Self-checking bench for zero_run_serializer with DATA_WIDTH = 8.
//
// A reference model builds the expected bit stream of each run as a queue.
// It holds N zeros, plus a terminating one when N is below the width. A
// compare process checks every output against that queue on each falling
// edge. Directed runs also collect the serial bits and compare them against
// hand-written literals.

module tb_zero_run_serializer;

  localparam int DW = 8;

  logic          clk;
  logic          resetn;
  logic [3:0]    din;
  logic          din_valid;
  logic          din_ready;
  logic          dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic [DW-1:0] word;

  int vectors;
  int miscompares;

  zero_run_serializer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .word       (word)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A single comparison. It is counted, and it reports when it misses.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model. The queue holds the bits still owed to the consumer.
  // The block is ready once the queue has drained. A count is taken only
  // while ready.
  logic          exp_bit[$];
  logic          exp_last[$];
  logic          m_ready;
  logic [DW-1:0] m_word;
  logic          chk_en;
  int            m_nc;

  initial chk_en = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      exp_bit.delete();
      exp_last.delete();
      m_ready = 1'b1;
      m_word  = '0;
      chk_en  = 1'b1;
    end else if (chk_en) begin
      if (exp_bit.size() != 0) begin
        if (dout_ready) begin
          void'(exp_bit.pop_front());
          void'(exp_last.pop_front());
          if (exp_bit.size() == 0) m_ready = 1'b1;
        end
      end else if (m_ready && din_valid) begin
        m_nc = (int'(din) > DW) ? DW : int'(din);
        for (int i = 0; i < m_nc; i++) begin
          exp_bit.push_back(1'b0);
          exp_last.push_back((m_nc == DW) && (i == m_nc - 1));
        end
        if (m_nc < DW) begin
          exp_bit.push_back(1'b1);
          exp_last.push_back(1'b1);
        end
        m_word  = (m_nc == DW) ? '0 : DW'(1 << m_nc);
        m_ready = 1'b0;
      end
    end
  end

  // Compare process. It checks the outputs against the model on every
  // falling edge, once the first reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_din_ready", 32'(din_ready), 32'(m_ready));
      checkOutput("model_dout_valid", 32'(dout_valid), 32'(exp_bit.size() != 0));
      if (exp_bit.size() != 0) begin
        checkOutput("model_dout", 32'(dout), 32'(exp_bit[0]));
        checkOutput("model_dout_last", 32'(dout_last), 32'(exp_last[0]));
      end
      checkOutput("model_word", 32'(word), 32'(m_word));
    end
  end

  // Offer one count. It is called just after a rising edge while the block
  // is idle, so the next rising edge accepts it.
  task automatic applyStimulus(input logic [3:0] d);
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // Collect one run of serial bits. dout_ready is held low for the first
  // 'stall' cycles and high after that. The task also records the cycle in
  // which dout_valid first appears and the total number of cycles taken.
  task automatic collectRun(input int stall, output logic [15:0] bits, output logic [15:0] lasts,
                            output int first_cyc, output int ncyc);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    bits = '0;
    lasts = '0;
    first_cyc = -1;
    ncyc = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      dout_ready = (cyc >= stall);
      @(negedge clk);
      if (dout_valid && first_cyc < 0) first_cyc = cyc;
      if (dout_valid && dout_ready) begin
        bits[k]  = dout;
        lasts[k] = dout_last;
        k++;
        if (dout_last || k >= 16) done = 1'b1;
      end
      @(posedge clk);
      #1;
      ncyc = cyc + 1;
    end
    if (!done) checkOutput("run_timeout", 32'd0, 32'd1);
  endtask

  logic [15:0] bits, lasts;
  int          first_cyc, ncyc;

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    din         = '0;
    din_valid   = 1'b0;
    dout_ready  = 1'b1;

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_din_ready", 32'(din_ready), 32'd1);
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_dout_last", 32'(dout_last), 32'd0);
    checkOutput("rst_word", 32'(word), 32'h00);
    @(posedge clk);
    #1;

    // N = 3: 0,0,0,1 on consecutive cycles, starting one cycle after accept.
    applyStimulus(4'd3);
    collectRun(0, bits, lasts, first_cyc, ncyc);
    checkOutput("n3_bits", 32'(bits), 32'b1000);
    checkOutput("n3_last", 32'(lasts), 32'b1000);
    checkOutput("n3_latency", 32'(first_cyc), 32'd0);
    checkOutput("n3_cycles", 32'(ncyc), 32'd4);
    checkOutput("n3_word", 32'(word), 32'h08);

    // N = 0: a lone terminator.
    applyStimulus(4'd0);
    collectRun(0, bits, lasts, first_cyc, ncyc);
    checkOutput("n0_bits", 32'(bits), 32'b1);
    checkOutput("n0_last", 32'(lasts), 32'b1);
    checkOutput("n0_cycles", 32'(ncyc), 32'd1);
    checkOutput("n0_word", 32'(word), 32'h01);

    // N = 8, then N = 15 (clamped to 8): eight zeros, with last on the eighth.
    applyStimulus(4'd8);
    collectRun(0, bits, lasts, first_cyc, ncyc);
    checkOutput("n8_bits", 32'(bits), 32'h0000);
    checkOutput("n8_last", 32'(lasts), 32'h0080);
    checkOutput("n8_cycles", 32'(ncyc), 32'd8);
    checkOutput("n8_word", 32'(word), 32'h00);
    applyStimulus(4'd15);
    collectRun(0, bits, lasts, first_cyc, ncyc);
    checkOutput("n15_bits", 32'(bits), 32'h0000);
    checkOutput("n15_last", 32'(lasts), 32'h0080);
    checkOutput("n15_cycles", 32'(ncyc), 32'd8);
    checkOutput("n15_word", 32'(word), 32'h00);

    // N = 2 with the consumer stalled for three cycles.
    applyStimulus(4'd2);
    collectRun(3, bits, lasts, first_cyc, ncyc);
    checkOutput("stall_bits", 32'(bits), 32'b100);
    checkOutput("stall_last", 32'(lasts), 32'b100);
    checkOutput("stall_latency", 32'(first_cyc), 32'd0);
    checkOutput("stall_cycles", 32'(ncyc), 32'd6);
    checkOutput("stall_word", 32'(word), 32'h04);

    // N = 5, reset after two zeros, then N = 1.
    dout_ready = 1'b1;
    applyStimulus(4'd5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("midrst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("midrst_din_ready", 32'(din_ready), 32'd1);
    checkOutput("midrst_word", 32'(word), 32'h00);
    @(posedge clk);
    #1;
    applyStimulus(4'd1);
    collectRun(0, bits, lasts, first_cyc, ncyc);
    checkOutput("n1_bits", 32'(bits), 32'b10);
    checkOutput("n1_last", 32'(lasts), 32'b10);
    checkOutput("n1_word", 32'(word), 32'h02);

    // din_valid held high with N = 4. The next accept happens only in the
    // cycle after the handshake on the last bit.
    din        = 4'd4;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_din_ready_c%0d", cyc), 32'(din_ready), 32'(cyc == 5));
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    collectRun(0, bits, lasts, first_cyc, ncyc);
    checkOutput("hold_bits", 32'(bits), 32'b10000);
    checkOutput("hold_last", 32'(lasts), 32'b10000);
    checkOutput("hold_latency", 32'(first_cyc), 32'd0);
    checkOutput("hold_word", 32'(word), 32'h10);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/zero_run_serializer.md
ZERO_RUN_SERIALIZER -- requirements
Module: zero_run_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of the reconstructed word and the maximum run length.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port din, input, $clog2(DATA_WIDTH)+1 bits: trailing-zero count N of the word to be emitted.
REQ-005 SHALL have port din_valid, input, 1 bit: din holds a valid count.
REQ-006 SHALL have port din_ready, output, 1 bit: block can accept a count.
REQ-007 SHALL have port dout, output, 1 bit: current serial bit, LSB-first.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout holds a valid bit.
REQ-009 SHALL have port dout_ready, input, 1 bit: consumer accepts dout this cycle.
REQ-010 SHALL have port dout_last, output, 1 bit: the current dout is the final bit of the run.
REQ-011 SHALL have port word, output, DATA_WIDTH bits: the parallel word whose trailing-zero count equals the last accepted N.

Function
REQ-012 SHALL implement states IDLE, ZEROS and TERM; din_ready SHALL be 1 only in IDLE.
REQ-013 SHALL accept a count when din_valid and din_ready are both 1 at a rising edge.
REQ-014 SHALL clamp any accepted din greater than DATA_WIDTH to DATA_WIDTH (Nc = min(din, DATA_WIDTH)).
REQ-015 SHALL, on accept, register word = 1 << Nc for Nc < DATA_WIDTH, and word = 0 for Nc = DATA_WIDTH; word SHALL hold until the next accept.
REQ-016 SHALL, on accept with Nc > 0, enter ZEROS with the remaining-count register set to Nc.
REQ-017 SHALL, on accept with Nc = 0, enter TERM directly.
REQ-018 SHALL, in ZEROS, drive dout = 0 and dout_valid = 1.
REQ-019 SHALL, on each dout handshake in ZEROS, decrement the remaining count by 1.
REQ-020 SHALL, on the handshake when the remaining count is 1, go to TERM if Nc < DATA_WIDTH, or to IDLE if Nc = DATA_WIDTH.
REQ-021 SHALL, in TERM, drive dout = 1 and dout_valid = 1, and return to IDLE on handshake.
REQ-022 SHALL assert dout_last with the TERM bit; when Nc = DATA_WIDTH (no terminator), it SHALL assert dout_last with the final zero bit instead.
REQ-023 SHALL stall while dout_valid = 1 and dout_ready = 0: dout, dout_last, state and count held unchanged.
REQ-024 SHALL have first-bit latency of one cycle after accept (dout_valid rises on the cycle after the accepting edge).
REQ-025 SHALL reassert din_ready in the cycle after the final bit handshake; no same-cycle accept on the final handshake.
REQ-026 SHALL ignore din and din_valid outside IDLE.
REQ-027 SHALL produce a total bit count per accepted count of Nc+1 for Nc < DATA_WIDTH, or DATA_WIDTH for Nc = DATA_WIDTH.
REQ-028 SHALL register all outputs; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 SHALL, when resetn = 0 at a rising edge, force state IDLE, remaining count 0, dout = 0, dout_valid = 0, dout_last = 0, word = 0, and din_ready = 1 on the following cycle.
REQ-030 SHALL, on reset mid-run, abandon the run immediately with no further dout_valid; the next accepted count starts a fresh run.

Verification (DATA_WIDTH = 8)
REQ-031 SHALL pass: din = 3 accepted, dout_ready held 1 -> dout 0,0,0,1 on 4 consecutive cycles starting 1 cycle after accept; dout_last only on the 1; word = 8'h08.
REQ-032 SHALL pass: din = 0 -> single bit dout = 1 with dout_last = 1; word = 8'h01.
REQ-033 SHALL pass: din = 8, then din = 15 -> each gives 8 zero bits with dout_last on the 8th and no terminator; word = 8'h00 for both.
REQ-034 SHALL pass: din = 2 with dout_ready = 0 for 3 cycles after the first bit -> dout = 0 held valid and count unchanged; sequence completes as 0,0,1 once dout_ready = 1.
REQ-035 SHALL pass: resetn pulsed low after 2 of 5 zero bits for din = 5 -> dout_valid = 0 and din_ready = 1 after reset; subsequent din = 1 yields 0,1.
REQ-036 SHALL pass: din_valid held high with din = 4 during a run -> no new accept until the cycle after dout_last handshake.
